// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the decode-stage hazard controller.
// Holds the controller state encoding and the flush counter width.
package pipeline_hazard_ctrl_pkg;

   localparam int PHC_NREGS     = 32;
   localparam int PHC_ADDR_W    = 5;
   localparam int PHC_FLUSH_LEN = 2;
   localparam int PHC_CNT_W     = 32;
   localparam int PHC_FCNT_W    = 3;

   typedef enum logic [1:0] {
      PHC_RUN     = 2'd0,
      PHC_FLUSH   = 2'd1,
      PHC_MEMWAIT = 2'd2
   } phc_state_e;

   // The redirect cycle itself is the first flush cycle, so the counter
   // only has to cover the remaining len-1 cycles.
   function automatic logic [PHC_FCNT_W-1:0] flush_reload(input int len);
      return PHC_FCNT_W'(len - 1);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute/memory-side signals seen by the hazard controller.
// master = pipeline side driving events, slave = the controller.
interface pipeline_hazard_ctrl_if
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W = PHC_ADDR_W,
   parameter int CNT_W  = PHC_CNT_W
);

   logic              id_valid;
   logic [ADDR_W-1:0] id_rs1;
   logic              id_rs1_used;
   logic [ADDR_W-1:0] id_rs2;
   logic              id_rs2_used;
   logic [ADDR_W-1:0] id_rd;
   logic              id_is_load;
   logic              ld_done;
   logic [ADDR_W-1:0] ld_rd;
   logic              br_taken;
   logic              mem_busy;

   logic              stall_if;
   logic              stall_id;
   logic              flush_id;
   logic              bubble_ex;
   logic              freeze;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_is_load,
      output ld_done, ld_rd, br_taken, mem_busy,
      input  stall_if, stall_id, flush_id, bubble_ex, freeze, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_is_load,
      input  ld_done, ld_rd, br_taken, mem_busy,
      output stall_if, stall_id, flush_id, bubble_ex, freeze, stall_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// One bit per architectural register marking a load in flight.
// One set port, one clear port (set wins on collision), two read ports.
module pipeline_hazard_ctrl_scoreboard #(
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_a,
   output logic              rd_b
);

   logic [NREGS-1:0] sb_reg;
   logic [NREGS-1:0] sb_next;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_bit
         // A clear in the same cycle belongs to an older load, so the set dominates.
         assign sb_next[gi] = (set_en && (set_addr == ADDR_W'(gi))) ||
                              (sb_reg[gi] && !(clr_en && (clr_addr == ADDR_W'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_reg <= '0;
      end else begin
         sb_reg <= sb_next;
      end
   end

   assign rd_a = sb_reg[rd_addr_a];
   assign rd_b = sb_reg[rd_addr_b];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: load-use stalls, post-redirect flush window and
// whole-pipeline freeze while data memory is busy, plus a stall-cycle counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NREGS     = PHC_NREGS,
   parameter int ADDR_W    = PHC_ADDR_W,
   parameter int FLUSH_LEN = PHC_FLUSH_LEN,
   parameter int CNT_W     = PHC_CNT_W
) (
   input logic                   clk,
   input logic                   rst_n,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam logic [PHC_FCNT_W-1:0] RELOAD = flush_reload(FLUSH_LEN);

   phc_state_e              state_reg, state_next;
   logic [PHC_FCNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
   logic                    pend_flush_reg, pend_flush_next;
   logic [CNT_W-1:0]        stall_cnt_reg;

   logic sb_rs1, sb_rs2, hazard, flush_active, issue, sb_set;
   logic stall_if_c, stall_id_c, flush_id_c, bubble_ex_c, freeze_c;

   pipeline_hazard_ctrl_scoreboard #(
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (sb_set),
      .set_addr  (bus.id_rd),
      .clr_en    (bus.ld_done),
      .clr_addr  (bus.ld_rd),
      .rd_addr_a (bus.id_rs1),
      .rd_addr_b (bus.id_rs2),
      .rd_a      (sb_rs1),
      .rd_b      (sb_rs2)
   );

   assign hazard = bus.id_valid && ((bus.id_rs1_used && sb_rs1) || (bus.id_rs2_used && sb_rs2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= PHC_RUN;
         flush_cnt_reg  <= '0;
         pend_flush_reg <= 1'b0;
         stall_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         flush_cnt_reg  <= flush_cnt_next;
         pend_flush_reg <= pend_flush_next;
         if (stall_id_c || freeze_c) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   // Priority: memory freeze, then redirect/flush, then load-use stall.
   always_comb begin
      state_next      = state_reg;
      flush_cnt_next  = flush_cnt_reg;
      pend_flush_next = pend_flush_reg;
      stall_if_c      = 1'b0;
      stall_id_c      = 1'b0;
      flush_id_c      = 1'b0;
      bubble_ex_c     = 1'b0;
      freeze_c        = 1'b0;
      flush_active    = (state_reg == PHC_FLUSH) ||
                        ((state_reg == PHC_MEMWAIT) && (pend_flush_reg || (flush_cnt_reg != '0)));

      if (bus.mem_busy) begin
         freeze_c        = 1'b1;
         stall_if_c      = 1'b1;
         stall_id_c      = 1'b1;
         state_next      = PHC_MEMWAIT;
         pend_flush_next = pend_flush_reg || bus.br_taken;
      end else begin
         pend_flush_next = 1'b0;
         if (bus.br_taken || flush_active) begin
            flush_id_c = 1'b1;
            if (bus.br_taken || pend_flush_reg) begin
               flush_cnt_next = RELOAD;
            end else begin
               flush_cnt_next = flush_cnt_reg - PHC_FCNT_W'(1);
            end
         end else if (hazard) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
         end
         state_next = (flush_cnt_next != '0) ? PHC_FLUSH : PHC_RUN;
      end
   end

   assign issue  = bus.id_valid && !hazard && !flush_id_c && !freeze_c;
   assign sb_set = issue && bus.id_is_load;

   // Outputs are held low for the whole time reset is asserted.
   assign bus.stall_if  = stall_if_c  && rst_n;
   assign bus.stall_id  = stall_id_c  && rst_n;
   assign bus.flush_id  = flush_id_c  && rst_n;
   assign bus.bubble_ex = bubble_ex_c && rst_n;
   assign bus.freeze    = freeze_c    && rst_n;
   assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;
   localparam int FL = 2;
   localparam logic [4:0] N = 5'b00000;  // {stall_if, stall_id, flush_id, bubble_ex, freeze}
   localparam logic [4:0] S = 5'b11010;
   localparam logic [4:0] F = 5'b00100;
   localparam logic [4:0] Z = 5'b11001;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

   pipeline_hazard_ctrl #(
      .NREGS(32), .ADDR_W(AW), .FLUSH_LEN(FL), .CNT_W(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       v;   logic [4:0] rs1;  logic u1;  logic [4:0] rs2; logic u2;
      logic [4:0] rd;  logic       ld;   logic ldd; logic [4:0] ldrd;
      logic       br;  logic       mb;   logic [4:0] exp; logic [3:0] cnt;
   } vec_t;

   int tests_run = 0;
   int tests_failed = 0;
   logic [4:0] outs;
   assign outs = {bus.stall_if, bus.stall_id, bus.flush_id, bus.bubble_ex, bus.freeze};

   bit sb_m[32];
   int flush_left, cnt_m, mb_left;
   bit owed;

   function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                               input logic u2, input int rd, input logic ld, input logic ldd,
                               input int ldrd, input logic br, input logic mb,
                               input logic [4:0] exp, input int cnt);
      vec_t t;
      t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
      t.rd = 5'(rd); t.ld = ld; t.ldd = ldd; t.ldrd = 5'(ldrd);
      t.br = br; t.mb = mb; t.exp = exp; t.cnt = 4'(cnt % 16);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.id_valid = t.v;   bus.id_rs1 = t.rs1; bus.id_rs1_used = t.u1;
      bus.id_rs2 = t.rs2;   bus.id_rs2_used = t.u2;
      bus.id_rd = t.rd;     bus.id_is_load = t.ld;
      bus.ld_done = t.ldd;  bus.ld_rd = t.ldrd;
      bus.br_taken = t.br;  bus.mem_busy = t.mb;
   endtask

   task automatic apply(input vec_t t, input string tag);
      drive(t);
      @(negedge clk);
      check($sformatf("%s.outs", tag), 32'(outs), 32'(t.exp));
      check($sformatf("%s.cnt", tag), 32'(bus.stall_cnt), 32'(t.cnt));
      $display("[TB] %s outs=%b cnt=%0d", tag, outs, bus.stall_cnt);
      @(posedge clk); #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0));
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[18];

   initial begin
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0));
      #3;
      check("reset.outs", 32'(outs), 32'(N));
      check("reset.cnt", 32'(bus.stall_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // load-use stall, flush beats hazard, set-wins collision, register 0
      tbl[0]  = mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, N, 0);
      tbl[1]  = mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, S, 0);
      tbl[2]  = mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, S, 1);
      tbl[3]  = mk(1, 3, 1, 2, 1, 0, 0, 1, 3, 0, 0, S, 2);
      tbl[4]  = mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, N, 3);
      tbl[5]  = mk(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, N, 3);
      tbl[6]  = mk(1, 7, 1, 0, 0, 1, 0, 0, 0, 1, 0, F, 3);
      tbl[7]  = mk(1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, F, 3);
      tbl[8]  = mk(1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, S, 3);
      tbl[9]  = mk(1, 7, 1, 0, 0, 1, 0, 1, 7, 0, 0, S, 4);
      tbl[10] = mk(1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, N, 5);
      tbl[11] = mk(1, 1, 1, 0, 0, 5, 1, 1, 5, 0, 0, N, 5);
      tbl[12] = mk(1, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, S, 5);
      tbl[13] = mk(0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, N, 6);
      tbl[14] = mk(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, N, 6);
      tbl[15] = mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, S, 6);
      tbl[16] = mk(1, 0, 1, 0, 0, 2, 0, 1, 0, 0, 0, S, 7);
      tbl[17] = mk(1, 0, 1, 0, 0, 2, 0, 1, 5, 0, 0, N, 8);
      for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // mem_busy for 5 cycles, redirect in the middle, loads inhibited throughout
      for (int i = 0; i < 5; i++)
         apply(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, (i == 2), 1, Z, 8 + i), $sformatf("mem%0d", i));
      apply(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, F, 13), "mem5");
      apply(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, F, 13), "mem6");
      apply(mk(1, 9, 1, 0, 0, 2, 0, 0, 0, 0, 0, N, 13), "mem7");

      // asynchronous reset in the middle of a flush window
      apply(mk(1, 1, 1, 0, 0, 2, 0, 0, 0, 1, 0, F, 13), "rstbr");
      drive(mk(1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, N, 0));
      #2;
      check("rst.pre_flush", 32'(bus.flush_id), 32'd1);
      rst_n = 1'b0;
      bus.br_taken = 1'b1;
      bus.mem_busy = 1'b1;
      #1;
      check("rst.outs", 32'(outs), 32'(N));
      check("rst.cnt", 32'(bus.stall_cnt), 32'd0);
      $display("[TB] rst_mid_flush outs=%b cnt=%0d", outs, bus.stall_cnt);
      @(posedge clk); #1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0));
      rst_n = 1'b1;

      // 17 stalled cycles on a 4-bit counter wrap it to 1
      apply(mk(1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, N, 0), "wrapld");
      for (int k = 0; k < 17; k++)
         apply(mk(1, 4, 1, 0, 0, 2, 0, 0, 0, 0, 0, S, k), $sformatf("wrap%0d", k));
      apply(mk(0, 4, 1, 0, 0, 2, 0, 1, 4, 0, 0, N, 1), "wrapend");

      // randomized run against the reference model
      reset_pulse();
      for (int r = 0; r < 32; r++) sb_m[r] = 1'b0;
      flush_left = 0; cnt_m = 0; owed = 1'b0; mb_left = 0;
      for (int n = 0; n < 400; n++) begin
         vec_t t;
         logic [4:0] e;
         bit haz, do_issue;
         t = mk(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 7), ($urandom_range(0, 9) == 0), 1'b0, N, 0);
         if (mb_left > 0) begin
            t.mb = 1'b1;
            mb_left--;
         end else if ($urandom_range(0, 19) == 0) begin
            mb_left = $urandom_range(0, 5);
            t.mb = 1'b1;
         end
         drive(t);
         @(negedge clk);
         haz = t.v && ((t.u1 && sb_m[t.rs1]) || (t.u2 && sb_m[t.rs2]));
         e = N;
         do_issue = 1'b0;
         if (t.mb) begin
            e = Z;
            if (t.br) owed = 1'b1;
         end else begin
            if (t.br || owed) flush_left = FL;
            owed = 1'b0;
            if (flush_left > 0) begin
               e = F;
               flush_left--;
            end else if (haz) begin
               e = S;
            end else begin
               do_issue = t.v;
            end
         end
         check($sformatf("rnd%0d.outs", n), 32'(outs), 32'(e));
         check($sformatf("rnd%0d.cnt", n), 32'(bus.stall_cnt), 32'(cnt_m));
         $display("[TB] rnd%0d mb=%b br=%b haz=%b outs=%b cnt=%0d", n, t.mb, t.br, haz, outs, bus.stall_cnt);
         if (e[3] || e[0]) cnt_m = (cnt_m + 1) % 16;
         if (t.ldd) sb_m[t.ldrd] = 1'b0;
         if (do_issue && t.ld) sb_m[t.rd] = 1'b1;
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
